// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller: opcodes, T-state/HALT encoding,
// and the control-word bit positions.
package sap1_pkg;

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        HALT = 3'd7
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JC  = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_W        = 13;
    localparam int CW_PC_OUT   = 12;
    localparam int CW_PC_INC   = 11;
    localparam int CW_PC_LOAD  = 10;
    localparam int CW_MAR_LOAD = 9;
    localparam int CW_RAM_OUT  = 8;
    localparam int CW_IR_LOAD  = 7;
    localparam int CW_IR_OUT   = 6;
    localparam int CW_A_LOAD   = 5;
    localparam int CW_A_OUT    = 4;
    localparam int CW_B_LOAD   = 3;
    localparam int CW_ALU_OUT  = 2;
    localparam int CW_ALU_SUB  = 1;
    localparam int CW_OUT_LOAD = 0;

endpackage

// File: rtl/sap1_ring_counter.sv
// T1..T6 ring state register with a HALT trap; synchronous active-high reset
// takes priority over everything, including HALT.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    halt_i,
    output tstate_e state_o
);

    tstate_e state_q, state_d;

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = T1;
        end else begin
            case (state_q)
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = T4;
                T4:      state_d = halt_i ? HALT : T5;
                T5:      state_d = T6;
                T6:      state_d = T1;
                HALT:    state_d = HALT;
                default: state_d = T1;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 microsequencer: ring-counter T-state plus combinational control decode.
// Build with SAP1_JUMP_EN defined to add JMP (0011) and JC (0100).
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            carry_flag,
    output logic            pc_out,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_load,
    output logic            ram_out,
    output logic            ir_load,
    output logic            ir_out,
    output logic            a_load,
    output logic            a_out,
    output logic            b_load,
    output logic            alu_out,
    output logic            alu_sub,
    output logic            out_load,
    output logic [2:0]      tstate,
    output logic            halted
);

    tstate_e          state;
    logic             halt_req;
    logic [CW_W-1:0]  cw;

    assign halt_req = (state == T4) && (opcode == OP_W'(OP_HLT));

    sap1_ring_counter u_ring (
        .clk     (clk),
        .reset   (reset),
        .halt_i  (halt_req),
        .state_o (state)
    );

`ifndef SAP1_JUMP_EN
    logic unused_carry;
    assign unused_carry = carry_flag;
`endif

    always_comb begin
        cw = '0;
        case (state)
            T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T2: cw[CW_PC_INC] = 1'b1;
            T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
            end
            T4: begin
                case (opcode)
                    OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_W'(OP_OUT): begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
`ifdef SAP1_JUMP_EN
                    OP_W'(OP_JMP): begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                    end
                    OP_W'(OP_JC): begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = carry_flag;
                    end
`endif
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_W'(OP_LDA): begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (opcode == OP_W'(OP_ADD) || opcode == OP_W'(OP_SUB)) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                    cw[CW_ALU_SUB] = (opcode == OP_W'(OP_SUB));
                end
            end
            default: ;
        endcase
        // Reset is synchronous for the state, but the outputs must be quiet
        // during the reset cycle itself, whatever state we happen to be in.
        if (reset) begin
            cw = '0;
        end
    end

    assign pc_out   = cw[CW_PC_OUT];
    assign pc_inc   = cw[CW_PC_INC];
    assign pc_load  = cw[CW_PC_LOAD];
    assign mar_load = cw[CW_MAR_LOAD];
    assign ram_out  = cw[CW_RAM_OUT];
    assign ir_load  = cw[CW_IR_LOAD];
    assign ir_out   = cw[CW_IR_OUT];
    assign a_load   = cw[CW_A_LOAD];
    assign a_out    = cw[CW_A_OUT];
    assign b_load   = cw[CW_B_LOAD];
    assign alu_out  = cw[CW_ALU_OUT];
    assign alu_sub  = cw[CW_ALU_SUB];
    assign out_load = cw[CW_OUT_LOAD];

    assign tstate = reset ? 3'd0 : state;
    assign halted = !reset && (state == HALT);

endmodule

// File: tb/tb_sap1_controller.sv
// Directed scoreboard bench for sap1_controller; define SAP1_JUMP_EN to
// check the jump-enabled build.
module tb_sap1_controller;

    localparam logic [12:0] PC_OUT   = 13'h1000;
    localparam logic [12:0] PC_INC   = 13'h0800;
    localparam logic [12:0] PC_LOAD  = 13'h0400;
    localparam logic [12:0] MAR_LOAD = 13'h0200;
    localparam logic [12:0] RAM_OUT  = 13'h0100;
    localparam logic [12:0] IR_LOAD  = 13'h0080;
    localparam logic [12:0] IR_OUT   = 13'h0040;
    localparam logic [12:0] A_LOAD   = 13'h0020;
    localparam logic [12:0] A_OUT    = 13'h0010;
    localparam logic [12:0] B_LOAD   = 13'h0008;
    localparam logic [12:0] ALU_OUT  = 13'h0004;
    localparam logic [12:0] ALU_SUB  = 13'h0002;
    localparam logic [12:0] OUT_LOAD = 13'h0001;
    localparam logic [12:0] NONE     = 13'h0000;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, out_load;
    logic [2:0] tstate;
    logic       halted;

    logic [16:0] exp_q[$];
    string       name_q[$];
    int          check_cnt = 0;
    int          pass_cnt  = 0;
    bit          inv_en    = 0;

    sap1_controller #(.OP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .pc_out     (pc_out),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .mar_load   (mar_load),
        .ram_out    (ram_out),
        .ir_load    (ir_load),
        .ir_out     (ir_out),
        .a_load     (a_load),
        .a_out      (a_out),
        .b_load     (b_load),
        .alu_out    (alu_out),
        .alu_sub    (alu_sub),
        .out_load   (out_load),
        .tstate     (tstate),
        .halted     (halted)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] e(input logic [2:0] t, input logic h, input logic [12:0] c);
        return {t, h, c};
    endfunction

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic step(input logic rst, input logic [3:0] op, input logic cf,
                        input logic [16:0] exp_v, input string nm);
        @(posedge clk);
        #1;
        reset      = rst;
        opcode     = op;
        carry_flag = cf;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    task automatic fetch(input logic [3:0] op, input logic cf, input string nm);
        step(0, op, cf, e(3'd0, 0, PC_OUT | MAR_LOAD), {nm, "_t1"});
        step(0, op, cf, e(3'd1, 0, PC_INC),            {nm, "_t2"});
        step(0, op, cf, e(3'd2, 0, RAM_OUT | IR_LOAD), {nm, "_t3"});
    endtask

    task automatic instr(input logic [3:0] op, input logic cf,
                         input logic [12:0] c4, input logic [12:0] c5, input logic [12:0] c6,
                         input string nm);
        fetch(op, cf, nm);
        step(0, op, cf, e(3'd3, 0, c4), {nm, "_t4"});
        step(0, op, cf, e(3'd4, 0, c5), {nm, "_t5"});
        step(0, op, cf, e(3'd5, 0, c6), {nm, "_t6"});
    endtask

    // scoreboard monitor plus per-cycle bus/PC invariants
    always @(negedge clk) begin
        logic [16:0] act;
        logic [16:0] exp_v;
        string       nm;
        int          drivers;
        act = {tstate, halted, pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load,
               ir_out, a_load, a_out, b_load, alu_out, alu_sub, out_load};
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            check_cnt = check_cnt + 1;
            if (act === exp_v) pass_cnt = pass_cnt + 1;
            else $display("FAIL %s: got tstate=%0d halted=%0b ctrl=%013b, expected tstate=%0d halted=%0b ctrl=%013b",
                          nm, act[16:14], act[13], act[12:0], exp_v[16:14], exp_v[13], exp_v[12:0]);
        end
        if (inv_en) begin
            drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
            check_cnt = check_cnt + 1;
            if (drivers <= 1 && !(pc_inc && pc_load)) pass_cnt = pass_cnt + 1;
            else $display("FAIL bus_invariant @%0t: drivers=%0d pc_inc=%0b pc_load=%0b, expected drivers<=1 and not both",
                          $time, drivers, pc_inc, pc_load);
        end
    end

    initial begin
        logic [12:0] jmp_c4, jc0_c4, jc1_c4;
`ifdef SAP1_JUMP_EN
        jmp_c4 = IR_OUT | PC_LOAD;
        jc0_c4 = IR_OUT;
        jc1_c4 = IR_OUT | PC_LOAD;
`else
        jmp_c4 = NONE;
        jc0_c4 = NONE;
        jc1_c4 = NONE;
`endif
        reset      = 1'b1;
        opcode     = 4'b0000;
        carry_flag = 1'b0;

        step(1, 4'b0000, 0, e(3'd0, 0, NONE), "reset_0");
        inv_en = 1;
        step(1, 4'b0000, 0, e(3'd0, 0, NONE), "reset_1");

        instr(4'b0000, 0, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, NONE, "lda");
        instr(4'b0010, 0, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD | ALU_SUB, "sub");
        instr(4'b0001, 1, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, "add");
        instr(4'b1110, 0, A_OUT | OUT_LOAD, NONE, NONE, "out");
        instr(4'b0101, 1, NONE, NONE, NONE, "nop");
        instr(4'b0011, 0, jmp_c4, NONE, NONE, "jmp");
        instr(4'b0100, 0, jc0_c4, NONE, NONE, "jc_c0");
        instr(4'b0100, 1, jc1_c4, NONE, NONE, "jc_c1");

        // reset pulsed in T5 of ADD abandons the instruction
        fetch(4'b0001, 0, "add_rst");
        step(0, 4'b0001, 0, e(3'd3, 0, IR_OUT | MAR_LOAD), "add_rst_t4");
        step(1, 4'b0001, 0, e(3'd0, 0, NONE), "add_rst_t5");
        step(0, 4'b0001, 0, e(3'd0, 0, PC_OUT | MAR_LOAD), "add_rst_after");
        step(0, 4'b0001, 0, e(3'd1, 0, PC_INC), "add_rst_t2");

        // HLT from a clean start
        step(1, 4'b1111, 0, e(3'd0, 0, NONE), "hlt_reset");
        fetch(4'b1111, 0, "hlt");
        step(0, 4'b1111, 0, e(3'd3, 0, NONE), "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            step(0, (i % 2 == 0) ? 4'b0001 : 4'b1111, 1, e(3'd7, 1, NONE), "halt_hold");
        end
        step(1, 4'b0000, 0, e(3'd0, 0, NONE), "halt_reset");
        instr(4'b0000, 0, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, NONE, "lda_after_halt");

        // random opcode soak; only the invariants are checked here
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            opcode     = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 99) == 0);
        end
        step(1, 4'b0000, 0, e(3'd0, 0, NONE), "soak_reset");
        step(0, 4'b0000, 0, e(3'd0, 0, PC_OUT | MAR_LOAD), "soak_t1");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check_cnt = check_cnt + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
